// File: rtl/enc424j600_pkg.sv
// Shared ENC424J600 SPI instruction definitions: opcode constants, instruction
// classes and transfer direction.
package enc424j600_pkg;

  localparam logic [7:0] OP_RCR      = 8'h00;
  localparam logic [7:0] OP_RCRU     = 8'h20;
  localparam logic [7:0] OP_WCRU     = 8'h22;
  localparam logic [7:0] OP_BFSU     = 8'h24;
  localparam logic [7:0] OP_BFCU     = 8'h26;
  localparam logic [7:0] OP_RGPDATA  = 8'h28;
  localparam logic [7:0] OP_WGPDATA  = 8'h2A;
  localparam logic [7:0] OP_WCR      = 8'h40;
  localparam logic [7:0] OP_WGPRDPT  = 8'h60;
  localparam logic [7:0] OP_RGPRDPT  = 8'h62;
  localparam logic [7:0] OP_BFS      = 8'h80;
  localparam logic [7:0] OP_BFC      = 8'hA0;
  localparam logic [7:0] OP_RBSEL    = 8'hC8;

  // ONE: opcode only, TWO: opcode+1 byte, THREE: opcode+2 bytes,
  // NBANK/NUNBANK: variable length with 1- or 2-byte header.
  typedef enum logic [2:0] {
    CLS_ONE     = 3'd0,
    CLS_TWO     = 3'd1,
    CLS_THREE   = 3'd2,
    CLS_NBANK   = 3'd3,
    CLS_NUNBANK = 3'd4
  } op_class_e;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_e;

  function automatic logic is_nclass(input op_class_e cls);
    return (cls == CLS_NBANK) || (cls == CLS_NUNBANK);
  endfunction

endpackage

// File: rtl/enc424j600_opdecode.sv
// Combinational ENC424J600 opcode decode: header length, fixed data length or
// variable (N) length, and transfer direction.
module enc424j600_opdecode
  import enc424j600_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic       o_hdr2,
  output logic       o_nvar,
  output logic [1:0] o_fixed_len,
  output dir_e       o_dir
);

  op_class_e w_class;

  always_comb begin
    w_class = CLS_NBANK;
    if (i_opcode == OP_RBSEL)                    w_class = CLS_TWO;
    else if (i_opcode[7:6] == 2'b11)             w_class = CLS_ONE;
    else if (i_opcode[7:5] == 3'b011)            w_class = CLS_THREE;
    else if (i_opcode[7:3] == OP_RCRU[7:3])      w_class = CLS_NUNBANK;
  end

  always_comb begin
    o_dir = DIR_WR;
    case (w_class)
      CLS_TWO:     o_dir = DIR_RD;
      CLS_THREE:   o_dir = i_opcode[1] ? DIR_RD : DIR_WR;
      CLS_NUNBANK: o_dir = (i_opcode == OP_RCRU) ? DIR_RD : DIR_WR;
      CLS_NBANK: begin
        // 0x00-0x1F reads, 0x28-0x3F read unless bit1, 0x40-0xBF writes
        if (i_opcode[7:5] == 3'b000)      o_dir = DIR_RD;
        else if (i_opcode[7:5] == 3'b001) o_dir = i_opcode[1] ? DIR_WR : DIR_RD;
        else                              o_dir = DIR_WR;
      end
      default:     o_dir = DIR_WR;
    endcase
  end

  always_comb begin
    o_fixed_len = 2'd0;
    case (w_class)
      CLS_TWO:   o_fixed_len = 2'd1;
      CLS_THREE: o_fixed_len = 2'd2;
      default:   o_fixed_len = 2'd0;
    endcase
  end

  assign o_hdr2 = (w_class == CLS_NUNBANK);
  assign o_nvar = is_nclass(w_class);

endmodule

// File: rtl/spi_master_enc424j600.sv
// SPI mode-0 master running one ENC424J600 instruction per request, with
// byte-wide write/read payload streams.
module spi_master_enc424j600
  import enc424j600_pkg::*;
#(
  parameter int CLK_HALF_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] opbyte,
  input  logic        opbyte_valid,
  input  logic [10:0] nbyte_num,
  input  logic [7:0]  wrdat_byte,
  input  logic        wrdat_valid,
  output logic        wrdat_ready,
  output logic [7:0]  rddat_byte,
  output logic        rddat_valid,
  output logic        txn_done,
  output logic        SCK,
  output logic        CS_N,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int DIV_W = (CLK_HALF_DIV > 1) ? $clog2(CLK_HALF_DIV) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CS_SETUP = 3'd1;
  localparam logic [2:0] S_HDR      = 3'd2;
  localparam logic [2:0] S_WR_REQ   = 3'd3;
  localparam logic [2:0] S_WR       = 3'd4;
  localparam logic [2:0] S_RD       = 3'd5;
  localparam logic [2:0] S_CS_HOLD  = 3'd6;
  localparam logic [2:0] S_GAP      = 3'd7;

  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [10:0]      r_nrem;
  logic [7:0]       r_tx;
  logic [7:0]       r_rx;
  logic [7:0]       r_addr;
  logic             r_hdr2;
  logic             r_hdr_second;
  logic             r_dir_rd;
  logic             r_sck;
  logic             r_cs_n;
  logic             r_mosi;
  logic             r_rd_fire;
  logic             r_rddat_valid;
  logic [7:0]       r_rddat_byte;
  logic             r_done_pend;
  logic             r_txn_done;
  logic             r_gap_half;

  logic        w_hdr2;
  logic        w_nvar;
  logic [1:0]  w_fixed_len;
  dir_e        w_dir;
  logic [10:0] w_ndata;
  logic        w_tick;
  logic        w_shift;

  enc424j600_opdecode u_dec (
    .i_opcode    (opbyte[7:0]),
    .o_hdr2      (w_hdr2),
    .o_nvar      (w_nvar),
    .o_fixed_len (w_fixed_len),
    .o_dir       (w_dir)
  );

  // nbyte_num counts the first data-phase byte as well, hence the -1
  assign w_ndata = w_nvar ? ((nbyte_num == 11'd0) ? 11'd0 : nbyte_num - 11'd1)
                          : {9'd0, w_fixed_len};
  assign w_tick  = (r_div == DIV_W'(CLK_HALF_DIV - 1));
  assign w_shift = (r_state == S_HDR) || (r_state == S_WR) || (r_state == S_RD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_bit         <= 3'd0;
      r_nrem        <= 11'd0;
      r_tx          <= 8'h00;
      r_rx          <= 8'h00;
      r_addr        <= 8'h00;
      r_hdr2        <= 1'b0;
      r_hdr_second  <= 1'b0;
      r_dir_rd      <= 1'b0;
      r_sck         <= 1'b0;
      r_cs_n        <= 1'b1;
      r_mosi        <= 1'b0;
      r_rd_fire     <= 1'b0;
      r_rddat_valid <= 1'b0;
      r_rddat_byte  <= 8'h00;
      r_done_pend   <= 1'b0;
      r_txn_done    <= 1'b0;
      r_gap_half    <= 1'b0;
    end else begin
      r_rddat_valid <= r_rd_fire;
      if (r_rd_fire) r_rddat_byte <= r_rx;
      r_rd_fire   <= 1'b0;
      r_txn_done  <= r_done_pend;
      r_done_pend <= 1'b0;

      // Divider is frozen in IDLE and while stalled waiting for write data
      if (r_state != S_IDLE && r_state != S_WR_REQ)
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);

      case (r_state)
        S_IDLE: begin
          if (opbyte_valid) begin
            r_state      <= S_CS_SETUP;
            r_cs_n       <= 1'b0;
            r_div        <= '0;
            r_bit        <= 3'd0;
            r_tx         <= opbyte[7:0];
            r_mosi       <= opbyte[7];
            r_addr       <= opbyte[15:8];
            r_hdr2       <= w_hdr2;
            r_hdr_second <= 1'b0;
            r_dir_rd     <= (w_dir == DIR_RD);
            r_nrem       <= w_ndata;
          end
        end
        S_CS_SETUP: begin
          if (w_tick) r_state <= S_HDR;
        end
        S_WR_REQ: begin
          if (wrdat_valid) begin
            r_tx    <= wrdat_byte;
            r_mosi  <= wrdat_byte[7];
            r_div   <= '0;
            r_bit   <= 3'd0;
            r_state <= S_WR;
          end
        end
        S_CS_HOLD: begin
          if (w_tick) begin
            r_cs_n      <= 1'b1;
            r_done_pend <= 1'b1;
            r_gap_half  <= 1'b0;
            r_state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_tick) begin
            if (r_gap_half) r_state <= S_IDLE;
            else            r_gap_half <= 1'b1;
          end
        end
        default: begin
          if (w_shift && w_tick) begin
            if (!r_sck) begin
              r_sck <= 1'b1;
              r_rx  <= {r_rx[6:0], MISO};
              if (r_state == S_RD && r_bit == 3'd7) r_rd_fire <= 1'b1;
            end else begin
              r_sck <= 1'b0;
              r_bit <= r_bit + 3'd1;
              if (r_bit != 3'd7) begin
                r_tx   <= {r_tx[6:0], 1'b0};
                r_mosi <= (r_state == S_RD) ? 1'b0 : r_tx[6];
              end else if (r_state == S_HDR) begin
                if (r_hdr2 && !r_hdr_second) begin
                  r_hdr_second <= 1'b1;
                  r_tx         <= r_addr;
                  r_mosi       <= r_addr[7];
                end else begin
                  r_tx   <= 8'h00;
                  r_mosi <= 1'b0;
                  if (r_nrem == 11'd0) r_state <= S_CS_HOLD;
                  else if (r_dir_rd)   r_state <= S_RD;
                  else                 r_state <= S_WR_REQ;
                end
              end else begin
                r_tx   <= 8'h00;
                r_mosi <= 1'b0;
                r_nrem <= r_nrem - 11'd1;
                if (r_nrem == 11'd1) r_state <= S_CS_HOLD;
                else if (r_state == S_WR) r_state <= S_WR_REQ;
              end
            end
          end
        end
      endcase
    end
  end

  assign wrdat_ready = (r_state == S_WR_REQ);
  assign rddat_byte  = r_rddat_byte;
  assign rddat_valid = r_rddat_valid;
  assign txn_done    = r_txn_done;
  assign SCK         = r_sck;
  assign CS_N        = r_cs_n;
  assign MOSI        = r_mosi;

endmodule

// File: tb/tb_spi_master_enc424j600.sv
// Directed bench for spi_master_enc424j600: instruction table plus stall,
// busy-request and mid-transfer reset sequences against a simple SPI slave.
module tb_spi_master_enc424j600;

  typedef struct packed {
    logic [15:0] op;
    logic [10:0] nb;
    logic [3:0]  hdr;   // header bytes
    logic [3:0]  n;     // data bytes
    logic        rd;
    logic [63:0] data;  // write bytes or slave read bytes, first byte in MSBs
    logic [7:0]  sck;   // expected SCK pulses
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] opbyte = '0;
  logic        opbyte_valid = 1'b0;
  logic [10:0] nbyte_num = '0;
  logic [7:0]  wrdat_byte = '0;
  logic        wrdat_valid = 1'b0;
  logic        wrdat_ready;
  logic [7:0]  rddat_byte;
  logic        rddat_valid;
  logic        txn_done;
  logic        SCK, CS_N, MOSI;
  logic        MISO;

  spi_master_enc424j600 #(.CLK_HALF_DIV(2)) dut (
    .clk(clk), .rst(rst), .opbyte(opbyte), .opbyte_valid(opbyte_valid),
    .nbyte_num(nbyte_num), .wrdat_byte(wrdat_byte), .wrdat_valid(wrdat_valid),
    .wrdat_ready(wrdat_ready), .rddat_byte(rddat_byte), .rddat_valid(rddat_valid),
    .txn_done(txn_done), .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // monitor state
  logic       mon_clr = 1'b0;
  int         mcyc = 0, n_sck = 0, n_rdv = 0, n_wrr = 0, n_done = 0, n_csf = 0;
  int         sl_cnt = 0, cs_rise = 0, done_at = 0;
  logic       p_sck = 1'b0, p_cs = 1'b1;
  logic [7:0] mb [16];
  logic [7:0] rb [16];
  logic [7:0] sl [8];

  always @(negedge clk) begin
    mcyc++;
    if (mon_clr) begin
      n_sck = 0; n_rdv = 0; n_wrr = 0; n_done = 0; n_csf = 0;
      sl_cnt = 0; cs_rise = 0; done_at = 0;
      for (int i = 0; i < 16; i++) begin mb[i] = 8'h00; rb[i] = 8'h00; end
    end else begin
      if (SCK && !p_sck) begin
        if (n_sck < 128) mb[n_sck >> 3] = {mb[n_sck >> 3][6:0], MOSI};
        n_sck++;
      end
      if (!SCK && p_sck) sl_cnt++;
      if (rddat_valid) begin
        if (n_rdv < 16) rb[n_rdv] = rddat_byte;
        n_rdv++;
      end
      if (wrdat_ready) n_wrr++;
      if (txn_done) begin n_done++; done_at = mcyc; end
      if (!CS_N && p_cs) n_csf++;
      if (CS_N && !p_cs) cs_rise = mcyc;
    end
    p_sck = SCK;
    p_cs  = CS_N;
  end

  // slave shifts its next bit out after each SCK fall
  always_comb begin
    int bi;
    logic [2:0] bsel;
    bi   = sl_cnt >> 3;
    if (bi > 7) bi = 7;
    bsel = 3'(7 - (sl_cnt % 8));
    MISO = sl[bi][bsel];
  end

  function automatic logic [7:0] getb(input logic [63:0] d, input int i);
    if (i < 0 || i > 7) return 8'h00;
    return d[63 - 8*i -: 8];
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int stall, input bit busy, input string tag);
    int widx, post, s0;
    bit seen, stalled, ok;
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(v.hdr)) sl[i] = 8'hFF;
      else                 sl[i] = getb(v.data, i - int'(v.hdr));
    end
    clear_mon();
    widx = 0; post = 0; seen = 0; stalled = 0;
    wrdat_valid = (stall == 0);
    wrdat_byte  = getb(v.data, 0);
    @(negedge clk);
    opbyte = v.op; nbyte_num = v.nb; opbyte_valid = 1'b1;
    @(negedge clk);
    opbyte_valid = 1'b0;
    for (int cyc = 0; cyc < 3000 && post < 8; cyc++) begin
      @(negedge clk);
      if (busy && cyc == 10) begin
        opbyte = 16'h0015; nbyte_num = 11'd5; opbyte_valid = 1'b1;
      end
      if (busy && cyc == 11) opbyte_valid = 1'b0;
      if (!stalled && stall > 0 && wrdat_ready) begin
        s0 = n_sck; ok = 1;
        repeat (stall) begin
          @(negedge clk);
          if (CS_N || SCK || !wrdat_ready) ok = 0;
        end
        if (n_sck != s0) ok = 0;
        chk({tag, "_stall_hold"}, 64'(ok), 64'd1);
        stalled = 1;
        wrdat_valid = 1'b1;
      end
      wrdat_byte = getb(v.data, widx);
      if (wrdat_ready && wrdat_valid) widx++;
      if (seen) post++;
      if (txn_done) seen = 1;
    end
    wrdat_valid = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_sck_pulses"}, 64'(n_sck), 64'(v.sck));
    chk({tag, "_txn_done_cnt"}, 64'(n_done), 64'd1);
    chk({tag, "_cs_fall_cnt"}, 64'(n_csf), 64'd1);
    chk({tag, "_done_after_cs"}, 64'(done_at - cs_rise), 64'd1);
    chk({tag, "_rddat_valid_cnt"}, 64'(n_rdv), v.rd ? 64'(v.n) : 64'd0);
    chk({tag, "_wrdat_ready_cyc"}, 64'(n_wrr), v.rd ? 64'd0 : 64'(int'(v.n) + stall));
    chk({tag, "_wr_consumed"}, 64'(widx), v.rd ? 64'd0 : 64'(v.n));
    for (int i = 0; i < int'(v.hdr) + int'(v.n); i++) begin
      if (i == 0)                e = v.op[7:0];
      else if (i < int'(v.hdr))  e = v.op[15:8];
      else if (v.rd)             e = 8'h00;
      else                       e = getb(v.data, i - int'(v.hdr));
      chk($sformatf("%s_mosi_b%0d", tag, i), 64'(mb[i]), 64'(e));
    end
    if (v.rd)
      for (int k = 0; k < int'(v.n); k++)
        chk($sformatf("%s_rd_b%0d", tag, k), 64'(rb[k]), 64'(getb(v.data, k)));
  endtask

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{16'h00DA, 11'd0, 4'd1, 4'd0, 1'b0, 64'h0,                  8'd8};
    tbl[1]  = '{16'h00C8, 11'd0, 4'd1, 4'd1, 1'b1, 64'h2400000000000000,   8'd16};
    tbl[2]  = '{16'h0062, 11'd9, 4'd1, 4'd2, 1'b1, 64'hA53C000000000000,   8'd24};
    tbl[3]  = '{16'h0060, 11'd0, 4'd1, 4'd2, 1'b0, 64'h8109000000000000,   8'd24};
    tbl[4]  = '{16'h0015, 11'd5, 4'd1, 4'd4, 1'b1, 64'h1122C3F000000000,   8'd40};
    tbl[5]  = '{16'h002A, 11'd6, 4'd1, 4'd5, 1'b0, 64'h01807E55AA000000,   8'd48};
    tbl[6]  = '{16'h8D20, 11'd5, 4'd2, 4'd4, 1'b1, 64'hDEADBEEF00000000,   8'd48};
    tbl[7]  = '{16'h8D22, 11'd6, 4'd2, 4'd5, 1'b0, 64'h123456789A000000,   8'd56};
    tbl[8]  = '{16'h0040, 11'd1, 4'd1, 4'd0, 1'b0, 64'h0,                  8'd8};
    tbl[9]  = '{16'h0000, 11'd0, 4'd1, 4'd0, 1'b1, 64'h0,                  8'd8};
    tbl[10] = '{16'h0081, 11'd2, 4'd1, 4'd1, 1'b0, 64'hC300000000000000,   8'd16};
    tbl[11] = '{16'h00FE, 11'd7, 4'd1, 4'd0, 1'b0, 64'h0,                  8'd8};
    for (int i = 0; i < 8; i++) sl[i] = 8'hFF;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({SCK, CS_N, MOSI, wrdat_ready, rddat_valid, txn_done, rddat_byte}),
        64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_outputs", 64'({SCK, CS_N, MOSI, wrdat_ready, rddat_valid, txn_done}),
        64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));

    for (int i = 0; i < 12; i++) run_vec(tbl[i], 0, 1'b0, $sformatf("v%0d", i));

    run_vec(tbl[3], 20, 1'b0, "stall");
    run_vec(tbl[1], 0, 1'b1, "busy");

    // reset in the middle of the second read byte of a 2-byte-header read
    sl[0] = 8'hFF; sl[1] = 8'hFF; sl[2] = 8'hDE; sl[3] = 8'hAD;
    sl[4] = 8'hBE; sl[5] = 8'hEF; sl[6] = 8'h00; sl[7] = 8'h00;
    clear_mon();
    @(negedge clk);
    opbyte = 16'h8D20; nbyte_num = 11'd5; opbyte_valid = 1'b1;
    @(negedge clk);
    opbyte_valid = 1'b0;
    repeat (110) @(negedge clk);
    chk("abort_pre_cs", 64'(CS_N), 64'd0);
    chk("abort_pre_rdv", 64'(n_rdv), 64'd1);
    #1 rst = 1'b1;
    #1 chk("abort_pins", 64'({CS_N, SCK, MOSI, rddat_valid, rddat_byte}),
           64'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(n_done), 64'd0);
    chk("abort_cs_idle", 64'(CS_N), 64'd1);

    run_vec(tbl[2], 0, 1'b0, "recover");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
